rob_alloc_ctrl: RTL
===================

ROB_ALLOC_CTRL -- requirements
Module: rob_alloc_ctrl

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 64, number of ROB entries (power of two).
REQ-002 SHALL have parameter IDX_W, default 6, ROB index width, log2(ROB_DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port grp_val_in, input, 1, a 4-wide fetch group is offered this cycle.
REQ-006 SHALL have port inst_val_in, input, 4, per-slot valid bits; bit i is slot i.
REQ-007 SHALL have port grp_rdy_out, output, 1, the group is accepted this cycle when grp_val_in is also high.
REQ-008 SHALL have port alloc_en_out, output, 4, per-slot ROB write enable; equals inst_val_in on accept, else 0.
REQ-009 SHALL have port rob_idx_out, output, 4*IDX_W, ROB index for slot i at bits [i*IDX_W +: IDX_W].
REQ-010 SHALL have port commit_cnt_in, input, 3, number of entries retired this cycle, 0..4.
REQ-011 SHALL have port flush_in, input, 1, mispredict recovery request.
REQ-012 SHALL have port flush_tail_in, input, IDX_W, new tail index after the flush.
REQ-013 SHALL have port free_cnt_out, output, IDX_W+1, number of free entries (registered).
REQ-014 SHALL have port full_out, output, 1, asserted when free_cnt_out==0.
REQ-015 SHALL have port empty_out, output, 1, asserted when free_cnt_out==ROB_DEPTH.
REQ-016 SHALL have port stall_out, output, 1, asserted while the FSM is in STALL.
REQ-017 SHALL have port err_out, output, 1, sticky underflow error flag.

Function
REQ-018 SHALL hold registers head, tail (IDX_W bits) and occ (IDX_W+1 bits); free_cnt_out = ROB_DEPTH - occ.
REQ-019 SHALL compute n = popcount(inst_val_in) combinationally.
REQ-020 SHALL drive grp_rdy_out = (state != RECOVER) & ~flush_in & (free_cnt_out >= n), using the start-of-cycle free count; same-cycle commits are not credited.
REQ-021 SHALL accept the group when grp_val_in & grp_rdy_out; a group with n==0 is accepted and allocates nothing.
REQ-022 SHALL assign compacted indices in slot order: valid slot i gets (tail + popcount(inst_val_in[i-1:0])) mod ROB_DEPTH; invalid slots, or any slot when not accepting, output 0.
REQ-023 SHALL output the indices and alloc_en_out combinationally, in the accept cycle; tail += n takes effect at the next edge, wrapping modulo ROB_DEPTH.
REQ-024 SHALL advance head by commit_cnt_in each edge, modulo ROB_DEPTH.
REQ-025 SHALL, without flush, update occ_next = occ + n_accepted - commit_cnt_in.
REQ-026 SHALL treat commit_cnt_in > occ + n_accepted as illegal: occ saturates to 0, head advances by occ only, and err_out sets and stays set until reset.
REQ-027 SHALL, on flush_in, set tail <= flush_tail_in and occ <= (flush_tail_in - head_next) mod ROB_DEPTH, where head_next includes the same-cycle commit; the result 0 means empty, and a flush to a full ROB is illegal and unsupported.
REQ-028 SHALL give flush priority over allocation in the same cycle; no allocation occurs.
REQ-029 SHALL implement a FSM with states RUN, STALL and RECOVER.
REQ-030 SHALL make these FSM transitions:
 - RUN->STALL: grp_val_in & ~grp_rdy_out & ~flush_in.
 - STALL->RUN: on accept.
 - any->RECOVER: on flush_in.
 - RECOVER->RUN: after exactly one cycle, unless flush_in is high again.
REQ-031 SHALL keep grp_rdy_out low for the whole RECOVER cycle.
REQ-032 SHALL, in STALL with grp_val_in dropped, return to RUN next edge.

Reset
REQ-033 SHALL, on rst_n low (asynchronous, mid-operation included), set head=0, tail=0, occ=0 and state=RUN.
REQ-034 SHALL, during reset, drive free_cnt_out=ROB_DEPTH, empty_out=1, full_out=0, stall_out=0, err_out=0 and alloc_en_out=0.
REQ-035 SHALL drive rob_idx_out=0 during reset.
REQ-036 SHALL, after release, allow an accept in the first cycle.

Verification
REQ-037 SHALL cover: after reset, inst_val_in=4'b1011 with grp_val_in -> alloc_en_out=1011, indices slot0=0, slot1=1, slot3=2, slot2=0; next cycle free_cnt_out=61.
REQ-038 SHALL cover wrap-around: tail=62 with 4 valid -> indices 62, 63, 0, 1; tail becomes 2.
REQ-039 SHALL cover full: occ=62, offer 4 valid -> grp_rdy_out=0 and stall_out=1 next cycle; commit 2 -> accepted the following cycle, full_out=1.
REQ-040 SHALL cover flush: head=10, occ=20, flush_in with flush_tail_in=15 and commit_cnt_in=1 -> occ=4 and tail=15; grp_rdy_out=0 for the flush cycle plus one RECOVER cycle.
REQ-041 SHALL cover underflow: occ=1 with commit_cnt_in=3 -> occ=0 and err_out=1 held until rst_n.
REQ-042 SHALL cover async reset asserted mid-STALL -> outputs reach the reset values without a clock edge.

Source files
------------

// File: rtl/rob_alloc_ctrl.sv
// Purpose: ROB allocation control: hands out up to 4 compacted ROB indices per fetch group, tracks head/tail/occupancy.
// Latency: indices and alloc enables are combinational in the accept cycle; pointer/occupancy/flag updates land at the next edge.
// Backpressure: grp_rdy_out drops when free entries < group size, during a flush and for one RECOVER cycle after it.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   grp_val_in, inst_val_in    fetch-group offer and per-slot valid bits
//   grp_rdy_out                group accepted when high together with grp_val_in
//   alloc_en_out, rob_idx_out  per-slot ROB write enable and index (slot i at [i*IDX_W +: IDX_W])
//   commit_cnt_in              entries retired this cycle (0..4)
//   flush_in, flush_tail_in    mispredict recovery and the tail to restore
//   free_cnt_out, full_out, empty_out, stall_out, err_out  status (registered state)
module rob_alloc_ctrl #(
  parameter int ROB_DEPTH = 64,
  parameter int IDX_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 grp_val_in,
  input  logic [3:0]           inst_val_in,
  output logic                 grp_rdy_out,
  output logic [3:0]           alloc_en_out,
  output logic [4*IDX_W-1:0]   rob_idx_out,
  input  logic [2:0]           commit_cnt_in,
  input  logic                 flush_in,
  input  logic [IDX_W-1:0]     flush_tail_in,
  output logic [IDX_W:0]       free_cnt_out,
  output logic                 full_out,
  output logic                 empty_out,
  output logic                 stall_out,
  output logic                 err_out
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(ROB_DEPTH);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   head_q, head_d;
  logic [IDX_W-1:0]   tail_q, tail_d;
  logic [IDX_W:0]     occ_q, occ_d;
  logic               err_q, err_d;

  // Running count of valid slots below each slot: this is the compaction offset.
  logic [1:0]         pre1, pre2, pre3;
  logic [2:0]         n_grp;
  logic [IDX_W-1:0]   slot_off [4];

  logic               accept;
  logic [IDX_W:0]     free_cnt;
  logic [IDX_W:0]     n_ext, n_acc;
  logic [IDX_W:0]     commit_w;
  logic [IDX_W+1:0]   avail;
  logic               underflow;
  logic [IDX_W-1:0]   head_adv;
  logic [IDX_W:0]     occ_nf;

  assign pre1  = {1'b0, inst_val_in[0]};
  assign pre2  = pre1 + {1'b0, inst_val_in[1]};
  assign pre3  = pre2 + {1'b0, inst_val_in[2]};
  assign n_grp = {1'b0, pre3} + {2'b00, inst_val_in[3]};

  assign slot_off[0] = '0;
  assign slot_off[1] = {{(IDX_W-2){1'b0}}, pre1};
  assign slot_off[2] = {{(IDX_W-2){1'b0}}, pre2};
  assign slot_off[3] = {{(IDX_W-2){1'b0}}, pre3};

  assign free_cnt = DEPTH_C - occ_q;
  assign n_ext    = {{(IDX_W-2){1'b0}}, n_grp};
  assign accept   = grp_val_in & grp_rdy_out;
  assign n_acc    = accept ? n_ext : '0;

  // FSM output process. Ready uses the start-of-cycle free count only;
  // commits in the same cycle are not credited. rst_n gating keeps the
  // allocation outputs quiet while reset is held.
  always_comb begin
    grp_rdy_out = rst_n & (state_q != ST_RECOVER) & ~flush_in & (free_cnt >= n_ext);
    stall_out   = (state_q == ST_STALL);
  end

  // FSM next-state process.
  always_comb begin
    state_d = state_q;
    if (flush_in) begin
      state_d = ST_RECOVER;
    end else begin
      case (state_q)
        ST_RUN:     if (grp_val_in & ~grp_rdy_out) state_d = ST_STALL;
        ST_STALL:   if (accept | ~grp_val_in)      state_d = ST_RUN;
        ST_RECOVER: state_d = ST_RUN;
        default:    state_d = ST_RUN;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Per-slot enables and compacted indices.
  always_comb begin
    alloc_en_out = '0;
    rob_idx_out  = '0;
    if (accept) begin
      alloc_en_out = inst_val_in;
      for (int i = 0; i < 4; i++) begin
        if (inst_val_in[i]) rob_idx_out[i*IDX_W +: IDX_W] = tail_q + slot_off[i];
      end
    end
  end

  // Pointer / occupancy update. An over-commit retires only what is held,
  // so head moves by the old occupancy and the error flag latches.
  always_comb begin
    commit_w  = {{(IDX_W-2){1'b0}}, commit_cnt_in};
    avail     = {1'b0, occ_q} + {1'b0, n_acc};
    underflow = ({1'b0, commit_w} > avail);
    if (underflow) begin
      head_adv = occ_q[IDX_W-1:0];
      occ_nf   = '0;
    end else begin
      head_adv = commit_w[IDX_W-1:0];
      occ_nf   = occ_q + n_acc - commit_w;
    end
    head_d = head_q + head_adv;
    err_d  = err_q | underflow;
    if (flush_in) begin
      // Distance from the post-commit head to the restored tail; 0 reads as empty.
      tail_d = flush_tail_in;
      occ_d  = {1'b0, flush_tail_in - head_d};
    end else begin
      tail_d = tail_q + n_acc[IDX_W-1:0];
      occ_d  = occ_nf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      err_q  <= err_d;
    end
  end

  assign free_cnt_out = free_cnt;
  assign full_out     = (occ_q == DEPTH_C);
  assign empty_out    = (occ_q == '0);
  assign err_out      = err_q;

endmodule
